// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunSel codes and multiply-sequencer state encoding.
package alu_pkg;

  localparam int unsigned MUL_W   = 16;
  localparam int unsigned PROD_W  = 2 * MUL_W;
  localparam int unsigned IDX_W   = $clog2(MUL_W);

  localparam logic [4:0] FUNSEL_ADD  = 5'b10100;
  localparam logic [4:0] FUNSEL_IDLE = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Start/done handshake plus the ALU operand/result bus owned by the sequencer.
interface alu_mul_sequencer_if;
  import alu_pkg::*;

  logic              start;
  logic [MUL_W-1:0]  op_a;
  logic [MUL_W-1:0]  op_b;
  logic              ready;
  logic              done;
  logic [PROD_W-1:0] product;
  logic [4:0]        alu_funsel;
  logic [PROD_W-1:0] alu_a;
  logic [PROD_W-1:0] alu_b;
  logic              alu_cin;
  logic [PROD_W-1:0] alu_out;

  // Parent side: instruction control unit and the ALU instance.
  modport master (
    output start, op_a, op_b, alu_out,
    input  ready, done, product, alu_funsel, alu_a, alu_b, alu_cin
  );

  // Sequencer side.
  modport slave (
    input  start, op_a, op_b, alu_out,
    output ready, done, product, alu_funsel, alu_a, alu_b, alu_cin
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// 16x16 unsigned shift-and-add multiplier that borrows the shared registered
// ALU for every accumulate step.
module alu_mul_sequencer
  import alu_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  alu_mul_sequencer_if.slave  bus
);

  mul_state_e        state;
  logic [PROD_W-1:0] mcand;
  logic [MUL_W-1:0]  mplier;
  logic [PROD_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic              ready_q;
  logic              done_q;
  logic [PROD_W-1:0] product_q;
  logic [4:0]        funsel_q;
  logic [PROD_W-1:0] alu_a_q;
  logic [PROD_W-1:0] alu_b_q;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MUL_W - 1);

  // Control FSM and datapath registers; every output is registered here.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      idx       <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
      funsel_q  <= FUNSEL_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand   <= {{(PROD_W-MUL_W){1'b0}}, bus.op_a};
            mplier  <= bus.op_b;
            acc     <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
            state   <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (mplier[idx]) begin
            alu_a_q  <= acc;
            alu_b_q  <= mcand << idx;
            funsel_q <= FUNSEL_ADD;
            state    <= S_ISSUE;
          end else if (idx == IDX_LAST) begin
            product_q <= acc;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // Operands stay stable so the ALU registers the sum at this edge.
        S_ISSUE: state <= S_WAIT;

        // The product is taken straight from alu_out on the last bit so it
        // is valid in the same cycle done is raised.
        S_WAIT: begin
          acc      <= bus.alu_out;
          funsel_q <= FUNSEL_IDLE;
          if (idx == IDX_LAST) begin
            product_q <= bus.alu_out;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_SCAN;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          done_q   <= 1'b0;
          ready_q  <= 1'b1;
          funsel_q <= FUNSEL_IDLE;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.product    = product_q;
  assign bus.alu_funsel = funsel_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural registered ALU.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] prod;
    int unsigned lat;
    int unsigned adds;
  } exp_t;

  logic clock;
  logic reset_n;
  alu_mul_sequencer_if bus ();

  exp_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu_mul_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ALU model: ADD sums, anything else passes A.
  always @(posedge clock) begin
    if (!reset_n) bus.alu_out <= '0;
    else if (bus.alu_funsel == 5'b10100) bus.alu_out <= bus.alu_a + bus.alu_b;
    else bus.alu_out <= bus.alu_a;
  end

  // Drive a request at the falling edge and let the next rising edge accept it.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit drop_start);
    exp_t e;
    @(negedge clock);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    e.prod = 32'(a) * 32'(b);
    e.lat  = 16 + 2 * $countones(b);
    e.adds = $countones(b);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (drop_start) bus.start = 1'b0;
  endtask

  // Count edges from acceptance until done, and ADD issues seen meanwhile.
  task automatic wait_done(output int unsigned lat, output int unsigned adds, output bit seen);
    bit prev_add;
    lat = 0; adds = 0; seen = 0; prev_add = 0;
    for (int unsigned k = 1; k <= 100 && !seen; k++) begin
      @(posedge clock);
      #1;
      if (bus.alu_funsel == 5'b10100 && !prev_add) adds++;
      prev_add = (bus.alu_funsel == 5'b10100);
      if (bus.done) begin
        seen = 1;
        lat  = k;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++;
    if (bus.product !== 32'h0) begin n_bad++; $display("FAIL reset_product got=%h exp=0", bus.product); end
    n_cmp++;
    if (bus.alu_funsel !== 5'b10000) begin n_bad++; $display("FAIL reset_funsel got=%b exp=10000", bus.alu_funsel); end
    n_cmp++;
    if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0 || bus.alu_cin !== 1'b0) begin
      n_bad++; $display("FAIL reset_alu_bus got a=%h b=%h cin=%b exp 0/0/0", bus.alu_a, bus.alu_b, bus.alu_cin);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mul(input string name, input logic [15:0] a, input logic [15:0] b);
    int unsigned lat, adds;
    bit seen;
    exp_t e;
    start_op(a, b, 1'b1);
    n_cmp++;
    if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL %s_busy_ready got=%b exp=0", name, bus.ready); end
    wait_done(lat, adds, seen);
    e = sb_q.pop_front();
    n_cmp++;
    if (bus.product !== e.prod) begin n_bad++; $display("FAIL %s_product got=%h exp=%h", name, bus.product, e.prod); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL %s_latency got=%0d exp=%0d (seen=%0d)", name, lat, e.lat, seen); end
    n_cmp++;
    if (adds !== e.adds) begin n_bad++; $display("FAIL %s_add_issues got=%0d exp=%0d", name, adds, e.adds); end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_after_done got done=%b ready=%b exp 0/1", name, bus.done, bus.ready);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned lat, adds;
    bit seen;
    exp_t e;
    start_op(16'd7, 16'd9, 1'b0);
    // Start stays high; these new operands must only be taken at the next acceptance.
    bus.op_a = 16'd2;
    bus.op_b = 16'h8000;
    wait_done(lat, adds, seen);
    e = sb_q.pop_front();
    n_cmp++;
    if (bus.product !== e.prod) begin n_bad++; $display("FAIL b2b_first_product got=%h exp=%h", bus.product, e.prod); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, e.lat); end
    e.prod = 32'h0001_0000; e.lat = 18; e.adds = 1;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.ready); end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept got ready=%b exp=0", bus.ready); end
    wait_done(lat, adds, seen);
    bus.start = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (bus.product !== e.prod) begin n_bad++; $display("FAIL b2b_second_product got=%h exp=%h", bus.product, e.prod); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, e.lat); end
    repeat (2) @(posedge clock);
  endtask

  task automatic test_reset_mid;
    bit any_done;
    exp_t e;
    start_op(16'h00FF, 16'h00FF, 1'b1);
    e = sb_q.pop_front();
    // Bit 0 set: ISSUE after edge 1, WAIT after edge 2.
    @(posedge clock);
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.alu_funsel !== 5'b10100) begin n_bad++; $display("FAIL mid_in_wait got funsel=%b exp=10100", bus.alu_funsel); end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.product !== 32'h0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got ready=%b product=%h done=%b exp 1/0/0", bus.ready, bus.product, bus.done);
    end
    any_done = 0;
    for (int unsigned k = 0; k < 60; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) any_done = 1;
    end
    n_cmp++;
    if (any_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done got=%b exp=0", any_done); end
    test_mul("mid_after", 16'd5, 16'd5);
  endtask

  task automatic test_op_change;
    int unsigned lat, adds;
    bit seen;
    exp_t e;
    start_op(16'h0010, 16'h0101, 1'b1);
    bus.op_a = 16'hFFFF;
    bus.op_b = 16'hFFFF;
    wait_done(lat, adds, seen);
    e = sb_q.pop_front();
    n_cmp++;
    if (bus.product !== e.prod) begin n_bad++; $display("FAIL opchg_product got=%h exp=%h", bus.product, e.prod); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL opchg_latency got=%0d exp=%0d", lat, e.lat); end
    @(posedge clock);
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    test_reset();
    test_mul("basic", 16'h0003, 16'h0005);
    test_mul("max", 16'hFFFF, 16'hFFFF);
    test_mul("zero", 16'h1234, 16'h0000);
    test_mul("single_top", 16'hABCD, 16'h8000);
    test_back_to_back();
    test_reset_mid();
    test_op_change();
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
